// File: rtl/vec_simd_mul_pipe.sv
// Pipelined SIMD integer multiplier: per-lane MUL/MULH/MULHU/MULHSU on 8/16/32-bit lanes,
// valid/ready handshake with a global stall and synchronous flush.
module vec_simd_mul_pipe #(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        sew,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_err,
  output logic              busy
);

  localparam int unsigned DW  = DATA_W;
  localparam int unsigned NST = PIPE_STAGES;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHU  = 2'b10,
    OP_MULHSU = 2'b11
  } op_e;

  logic [NST-1:0]             vld;
  logic [NST-1:0]             err_q;
  logic [NST-1:0][DW-1:0]     res_q;
  logic [NST:0]               vld_ext;
  logic [NST:0]               err_ext;
  logic [NST:0][DW-1:0]       res_ext;
  logic                       advance;
  logic [DW-1:0]              comb_res;
  logic [DW-1:0]              ax;
  logic [DW-1:0]              bx;
  logic [31:0]                lane;
  int unsigned                lane_w;

  // One lane: operands widened to 33 bits (sign or zero per op) so a single signed
  // multiply covers all four flavours; the result is confined to the lane's own bits.
  function automatic logic [31:0] lane_mul(input logic [31:0] x, input logic [31:0] y,
                                           input int unsigned w, input logic [1:0] o);
    logic [32:0]        m;
    logic [32:0]        xe;
    logic [32:0]        ye;
    logic [31:0]        xs;
    logic [31:0]        ys;
    logic signed [65:0] p;
    logic [65:0]        ph;
    m  = (33'd1 << w) - 33'd1;
    xe = {1'b0, x} & m;
    ye = {1'b0, y} & m;
    xs = x >> (w - 1);
    ys = y >> (w - 1);
    if ((o == OP_MULH || o == OP_MULHSU) && xs[0]) xe = xe | ~m;
    if (o == OP_MULH && ys[0]) ye = ye | ~m;
    p  = $signed({{33{xe[32]}}, xe}) * $signed({{33{ye[32]}}, ye});
    ph = (o == OP_MUL) ? p : (p >> w);
    return ph[31:0] & m[31:0];
  endfunction

  always_comb begin
    comb_res = '0;
    ax       = '0;
    bx       = '0;
    lane     = '0;
    case (sew)
      2'b00:   lane_w = 8;
      2'b01:   lane_w = 16;
      default: lane_w = 32;
    endcase
    if (sew != 2'b11) begin
      for (int unsigned i = 0; i < DW / 8; i++) begin
        if (i < DW / lane_w) begin
          ax       = a >> (i * lane_w);
          bx       = b >> (i * lane_w);
          lane     = lane_mul(ax[31:0], bx[31:0], lane_w, op);
          comb_res = comb_res | (DW'(lane) << (i * lane_w));
        end
      end
    end
  end

  assign advance    = !out_valid | out_ready;
  assign in_ready   = advance;
  assign out_valid  = vld[NST-1];
  assign out_result = res_q[NST-1];
  assign out_err    = err_q[NST-1] & out_valid;
  assign busy       = |vld;

  // Stage 0 takes the new op; stage k takes stage k-1 (works for a single stage too).
  assign vld_ext = {vld, in_valid};
  assign err_ext = {err_q, (sew == 2'b11)};
  assign res_ext = {res_q, comb_res};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld   <= '0;
      err_q <= '0;
      res_q <= '0;
    end else if (flush) begin
      vld <= '0;
    end else if (advance) begin
      vld   <= vld_ext[NST-1:0];
      err_q <= err_ext[NST-1:0];
      res_q <= res_ext[NST-1:0];
    end
  end

endmodule

// File: tb/tb_vec_simd_mul_pipe.sv
// Bench for vec_simd_mul_pipe (DATA_W=32, PIPE_STAGES=2): longint lane model with an
// expected-result queue, plus directed vectors with hand-computed results.
module tb_vec_simd_mul_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  sew = 2'b00;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_err;
  logic        busy;

  vec_simd_mul_pipe #(.DATA_W(32), .PIPE_STAGES(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .sew(sew), .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [31:0] obs_res[$];
  logic        obs_err[$];
  int          obs_cyc[$];
  int          obs_lat[$];

  function automatic logic [31:0] model(input logic [1:0] s, input logic [1:0] o,
                                        input logic [31:0] x, input logic [31:0] y);
    int unsigned     w;
    longint unsigned msk;
    longint unsigned ux;
    longint unsigned uy;
    longint unsigned lanev;
    longint          vx;
    longint          vy;
    longint          p;
    logic [63:0]     acc;
    if (s == 2'b11) return 32'h0;
    w   = (s == 2'b00) ? 8 : (s == 2'b01) ? 16 : 32;
    msk = (64'd1 << w) - 64'd1;
    acc = '0;
    for (int unsigned i = 0; i < 32 / w; i++) begin
      ux = ({32'h0, x} >> (i * w)) & msk;
      uy = ({32'h0, y} >> (i * w)) & msk;
      vx = ((o == 2'b01 || o == 2'b11) && ux >= (64'd1 << (w - 1))) ? longint'(ux - (64'd1 << w)) : longint'(ux);
      vy = (o == 2'b01 && uy >= (64'd1 << (w - 1))) ? longint'(uy - (64'd1 << w)) : longint'(uy);
      p  = vx * vy;
      lanev = (o == 2'b00) ? (longint'(p) & msk) : ((p >>> w) & msk);
      acc = acc | (lanev << (i * w));
    end
    return acc[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
    end
  endtask

  task automatic chk_obs(input string name, input int idx, input logic [31:0] res, input logic err);
    if (idx >= obs_res.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: got no result expected 0x%0h", name, res);
    end else begin
      chk(name, obs_res[idx], res);
      chk({name, "_err"}, obs_err[idx], err);
    end
  endtask

  // Model side: record every accepted op; flush or reset wipes everything in flight.
  always @(posedge clk) begin
    if (!reset || flush) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back('{model(sew, op, a, b), (sew == 2'b11), cyc});
    cyc++;
  end

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got 0x%0h expected none", out_result);
      end else begin
        cur = exp_q.pop_front();
        chk("out_result", out_result, cur.res);
        chk("out_err", out_err, cur.err);
        obs_res.push_back(out_result);
        obs_err.push_back(out_err);
        obs_cyc.push_back(cyc);
        obs_lat.push_back(cyc - cur.acc);
      end
    end
  end

  task automatic send(input logic [1:0] s, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    sew = s; op = o; a = x; b = y; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    // Reset state
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #2;
    reset = 1'b1;
    cycles(2);

    // 1: byte-lane MUL and latency
    base = obs_res.size();
    send(2'b00, 2'b00, 32'h04030201, 32'h02020202);
    chk("t1_not_early", out_valid, 0);
    cycles(1);
    chk("t1_valid", out_valid, 1);
    chk("t1_result", out_result, 32'h08060402);
    cycles(2);
    chk_obs("t1_obs", base, 32'h08060402, 1'b0);
    if (base < obs_lat.size()) chk("t1_latency", obs_lat[base], 2);

    // 2: halfword MULH
    base = obs_res.size();
    send(2'b01, 2'b01, 32'hFFFF0003, 32'h00020004);
    cycles(3);
    chk_obs("t2_mulh16", base, 32'hFFFF0000, 1'b0);

    // 3: all four ops on -1/-1 words, back-to-back
    base = obs_res.size();
    send(2'b10, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    send(2'b10, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    send(2'b10, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF);
    send(2'b10, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    cycles(4);
    chk_obs("t3_mul", base, 32'h00000001, 1'b0);
    chk_obs("t3_mulh", base + 1, 32'h00000000, 1'b0);
    chk_obs("t3_mulhu", base + 2, 32'hFFFFFFFE, 1'b0);
    chk_obs("t3_mulhsu", base + 3, 32'hFFFFFFFF, 1'b0);
    if (base + 3 < obs_cyc.size()) chk("t3_consecutive", obs_cyc[base + 3] - obs_cyc[base], 3);

    // 4: backpressure for 5 edges with 4 ops queued
    base = obs_res.size();
    out_ready = 1'b0;
    fork
      begin
        send(2'b10, 2'b00, 32'h00000003, 32'h00000005);
        send(2'b10, 2'b10, 32'h80000000, 32'h00000004);
        send(2'b01, 2'b00, 32'h00100010, 32'h00100010);
        send(2'b00, 2'b11, 32'h80808080, 32'h02020202);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("t4_in_ready_low", in_ready, 0);
        chk("t4_valid_stalled", out_valid, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_held_result", out_result, 32'h0000000F);
        chk("t4_still_valid", out_valid, 1);
        out_ready = 1'b1;
      end
    join
    cycles(6);
    chk("t4_count", obs_res.size() - base, 4);
    chk_obs("t4_r0", base, 32'h0000000F, 1'b0);
    chk_obs("t4_r1", base + 1, 32'h00000002, 1'b0);
    chk_obs("t4_r2", base + 2, 32'h01000100, 1'b0);
    chk_obs("t4_r3", base + 3, 32'hFFFFFFFF, 1'b0);

    // 5: flush with two ops in flight, then flush against an empty pipe with in_ready=1
    base = obs_res.size();
    out_ready = 1'b0;
    send(2'b10, 2'b00, 32'd7, 32'd6);
    send(2'b10, 2'b00, 32'd9, 32'd9);
    chk("t5_busy_before", busy, 1);
    flush = 1'b1;
    in_valid = 1'b1;
    sew = 2'b10; op = 2'b00; a = 32'd5; b = 32'd5;
    cycles(1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_valid", out_valid, 0);
      chk("t5_not_busy", busy, 0);
      cycles(1);
    end
    chk("t5_in_ready_empty", in_ready, 1);
    flush = 1'b1;
    in_valid = 1'b1;
    cycles(1);
    flush = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_dropped_valid", out_valid, 0);
      chk("t5_dropped_busy", busy, 0);
      cycles(1);
    end
    send(2'b10, 2'b10, 32'h80000000, 32'h80000000);
    cycles(3);
    chk("t5_count", obs_res.size() - base, 1);
    chk_obs("t5_after_flush", base, 32'h40000000, 1'b0);

    // 6: reserved sew, then asynchronous reset mid-stream
    base = obs_res.size();
    send(2'b11, 2'b00, 32'h12345678, 32'h11111111);
    cycles(3);
    chk_obs("t6_reserved", base, 32'h00000000, 1'b1);
    out_ready = 1'b0;
    send(2'b10, 2'b00, 32'd3, 32'd3);
    send(2'b10, 2'b00, 32'd4, 32'd4);
    chk("t6_valid_before_rst", out_valid, 1);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_result", out_result, 0);
    chk("t6_rst_err", out_err, 0);
    @(posedge clk); #2;
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t6_post_rst_valid", out_valid, 0);
      cycles(1);
    end
    chk("t6_post_rst_busy", busy, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
